seq_frame_ctrl: RTL and testbench
=================================

# seq_frame_ctrl

Frame controller for the serial ones-run detection path. It accepts a parallel frame through a start/ready handshake and shifts it out LSB-first as a qualified serial stream (`data_out`/`data_valid`) for the downstream sequence detector. It counts, in parallel, the runs of two or more consecutive 1s in the frame. It then reports the count with a one-cycle `done` pulse and supports abort mid-frame.

## Interface
- `WIDTH`, default 8: frame length in bits; legal range 2..32.
- `CNT_W`, default 4: width of `run_count`; must satisfy 2^CNT_W > floor((WIDTH+1)/3), so the count never overflows.
- `clk`  input  1  sole clock; all state changes on its rising edge.
- `rst`  input  1  reset, asynchronous and active-high.
- `start`  input  1  frame request; accepted only on an edge where `ready`=1 and `start`=1.
- `frame`  input  WIDTH  frame data, captured on the accepting edge.
- `abort`  input  1  terminates a frame in progress.
- `ready`  output  1  high only in IDLE; decoded from state.
- `data_out`  output  1  current serial bit, LSB first.
- `data_valid`  output  1  high exactly while `data_out` carries a frame bit.
- `done`  output  1  one-cycle pulse when `run_count` is final.
- `run_count`  output  CNT_W  number of runs of ≥2 consecutive 1s in the last completed frame.
- `aborted`  output  1  one-cycle pulse when a frame is abandoned.

## Operation
- Reset values:
  - state = IDLE, so `ready`=1.
  - `data_out`, `data_valid`, `done` and `aborted` are 0.
  - `run_count`, the internal shift register, bit counter, `prev` and `in_run` flags are all 0.
- State machine: IDLE, SHIFT, REPORT.
- IDLE:
  - On `start`=1, load `frame` into the shift register and clear the bit counter, `prev`, `in_run` and the internal count.
  - Then go to SHIFT.
  - `abort` is ignored in IDLE. `start` and `abort` high together in IDLE start the frame.
- SHIFT:
  - `data_valid`=1 and `data_out`=sreg[0].
  - Each edge shifts sreg right by one and increments the bit counter.
  - After WIDTH shift edges, go to REPORT.
- Run counting, on each SHIFT edge, with b = sreg[0]:
  - If b=1, `prev`=1 and `in_run`=0: increment the count and set `in_run`=1.
  - If b=0: clear `in_run`.
  - Always set `prev` = b.
  - `prev` is cleared at frame acceptance, so runs never chain across frame boundaries.
- REPORT:
  - Lasts one cycle; `done`=1.
  - `run_count` already holds the final count, loaded on the last SHIFT edge.
  - Then go to IDLE.
  - `start` during REPORT is ignored (`ready`=0). If it is still held in the next IDLE cycle, it is accepted there.
- `run_count` holds its value until the next completed frame or abort.
- Abort in SHIFT:
  - On the edge sampling `abort`=1, state goes to IDLE and `data_valid` drops.
  - `run_count` is cleared to 0 and `aborted` pulses for the following cycle. No `done` is issued.
- `abort` in REPORT is ignored; the frame is treated as complete.
- `start` in SHIFT or REPORT is ignored, and `frame` is not resampled.
- `rst` asserted at any time forces the reset values immediately, without waiting for a clock edge. The frame in progress is lost, and no `done` or `aborted` pulse is issued.

## Timing
- Call the accepting edge E0.
- Cycles between E0 and E(WIDTH): `data_valid`=1, with bit k presented between E(k) and E(k+1).
- `done`=1 between E(WIDTH) and E(WIDTH+1); `ready` returns to 1 after E(WIDTH+1).
- Throughput is one frame per WIDTH+2 cycles, counting one mandatory IDLE cycle between frames.
- Abort sampled at edge Ea: `aborted`=1 and `ready`=1 in the cycle after Ea, and the next start can be accepted at Ea+1.
- All outputs except `ready` are registered.

## Test plan
- Reset, then WIDTH=8 with `frame`=8'h6E (bits LSB-first 0,1,1,1,0,1,1,0):
  - stream matches bit-for-bit over 8 `data_valid` cycles;
  - `done` pulses 9 cycles after acceptance with `run_count`=2.
- `frame`=8'h55 → `run_count`=0. `frame`=8'hFF → `run_count`=1. `frame`=8'hDB (1,1,0,1,1,0,1,1) → `run_count`=3, the maximum for WIDTH=8.
- Back-to-back with `start` held high:
  - 8'h81, then 8'h03;
  - 8'h81 → `run_count`=0: its final 1 must not pair with the next frame's first 1;
  - 8'h03 → `run_count`=1;
  - second acceptance occurs exactly one IDLE cycle after `done`.
- `abort` asserted in the 3rd SHIFT cycle of 8'hFF:
  - `data_valid` drops next cycle;
  - `aborted` pulses once, `run_count`=0, no `done`;
  - `ready`=1;
  - a new 8'h06 frame then gives `run_count`=1.
- `start` pulsed mid-SHIFT with a different `frame`: ignored; the original frame's stream and count are unchanged.
- `rst` asserted between clock edges mid-frame:
  - all outputs return to reset values immediately, with `ready`=1;
  - after release, a fresh 8'h6E frame gives `run_count`=2.

Source files
------------

// File: rtl/seq_frame_ctrl.sv
// Frame controller: accepts a parallel frame, streams it out LSB-first and
// counts runs of two or more consecutive 1s, reporting via done/aborted pulses.
module seq_frame_ctrl #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] frame,
   input  logic             abort,
   output logic             ready,
   output logic             data_out,
   output logic             data_valid,
   output logic             done,
   output logic [CNT_W-1:0] run_count,
   output logic             aborted
);

   localparam int unsigned BitW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {StIdle, StShift, StReport} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] sreg_q, sreg_d;
   logic [BitW-1:0]  bit_cnt_q, bit_cnt_d;
   logic             prev_q, prev_d;
   logic             in_run_q, in_run_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] run_count_q, run_count_d;
   logic             valid_q, valid_d;
   logic             done_q, done_d;
   logic             aborted_q, aborted_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sreg_q      <= '0;
         bit_cnt_q   <= '0;
         prev_q      <= 1'b0;
         in_run_q    <= 1'b0;
         cnt_q       <= '0;
         run_count_q <= '0;
         valid_q     <= 1'b0;
         done_q      <= 1'b0;
         aborted_q   <= 1'b0;
      end else begin
         sreg_q      <= sreg_d;
         bit_cnt_q   <= bit_cnt_d;
         prev_q      <= prev_d;
         in_run_q    <= in_run_d;
         cnt_q       <= cnt_d;
         run_count_q <= run_count_d;
         valid_q     <= valid_d;
         done_q      <= done_d;
         aborted_q   <= aborted_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      sreg_d      = sreg_q;
      bit_cnt_d   = bit_cnt_q;
      prev_d      = prev_q;
      in_run_d    = in_run_q;
      cnt_d       = cnt_q;
      run_count_d = run_count_q;
      valid_d     = valid_q;
      done_d      = 1'b0;
      aborted_d   = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               sreg_d    = frame;
               bit_cnt_d = '0;
               prev_d    = 1'b0;
               in_run_d  = 1'b0;
               cnt_d     = '0;
               valid_d   = 1'b1;
               state_d   = StShift;
            end
         end
         StShift: begin
            if (abort) begin
               // Clearing sreg keeps data_out quiet while idle after an abort
               sreg_d      = '0;
               valid_d     = 1'b0;
               run_count_d = '0;
               aborted_d   = 1'b1;
               state_d     = StIdle;
            end else begin
               sreg_d    = sreg_q >> 1;
               bit_cnt_d = bit_cnt_q + 1'b1;
               prev_d    = sreg_q[0];
               if (sreg_q[0]) begin
                  if (prev_q && !in_run_q) begin
                     cnt_d    = cnt_q + 1'b1;
                     in_run_d = 1'b1;
                  end
               end else begin
                  in_run_d = 1'b0;
               end
               if (bit_cnt_q == BitW'(WIDTH - 1)) begin
                  valid_d     = 1'b0;
                  done_d      = 1'b1;
                  run_count_d = cnt_d;
                  state_d     = StReport;
               end
            end
         end
         StReport: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   assign ready      = (state_q == StIdle);
   assign data_out   = sreg_q[0];
   assign data_valid = valid_q;
   assign done       = done_q;
   assign run_count  = run_count_q;
   assign aborted    = aborted_q;

endmodule

// File: tb/tb_seq_frame_ctrl.sv
// Directed bench for seq_frame_ctrl with hand-computed run counts and timing.
module tb_seq_frame_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] frame;
   logic       abort;
   logic       ready;
   logic       data_out;
   logic       data_valid;
   logic       done;
   logic [3:0] run_count;
   logic       aborted;

   int n_checks = 0;
   int n_pass   = 0;

   seq_frame_ctrl #(
      .WIDTH(8),
      .CNT_W(4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .frame      (frame),
      .abort      (abort),
      .ready      (ready),
      .data_out   (data_out),
      .data_valid (data_valid),
      .done       (done),
      .run_count  (run_count),
      .aborted    (aborted)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end else begin
         n_pass++;
      end
   endtask

   // Called on a negedge in IDLE; returns on the negedge after the accepting edge.
   task automatic start_frame(input logic [7:0] f);
      check("ready_before_start", {31'b0, ready}, 32'd1);
      start = 1'b1;
      frame = f;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Called in the first SHIFT cycle; returns in the done cycle.
   task automatic check_frame(input string tag, input logic [7:0] f, input logic [3:0] exp_cnt,
                              input bit inject);
      logic [7:0] stream;
      logic       valid_all;
      logic       any_done;
      stream    = '0;
      valid_all = 1'b1;
      any_done  = 1'b0;
      for (int k = 0; k < 8; k++) begin
         stream[k] = data_out;
         valid_all = valid_all & data_valid & ~ready;
         any_done  = any_done | done;
         if (inject && k == 3) begin
            start = 1'b1;
            frame = ~f;
         end else if (inject) begin
            start = 1'b0;
         end
         @(negedge clk);
      end
      start = 1'b0;
      check({tag, "_stream"}, {24'b0, stream}, {24'b0, f});
      check({tag, "_valid"}, {31'b0, valid_all}, 32'd1);
      check({tag, "_no_early_done"}, {31'b0, any_done}, 32'd0);
      check({tag, "_done"}, {31'b0, done}, 32'd1);
      check({tag, "_valid_off"}, {31'b0, data_valid}, 32'd0);
      check({tag, "_ready_low"}, {31'b0, ready}, 32'd0);
      check({tag, "_count"}, {28'b0, run_count}, {28'b0, exp_cnt});
   endtask

   task automatic finish_frame(input string tag, input logic [3:0] exp_cnt);
      @(negedge clk);
      check({tag, "_done_drop"}, {31'b0, done}, 32'd0);
      check({tag, "_ready_back"}, {31'b0, ready}, 32'd1);
      check({tag, "_count_hold"}, {28'b0, run_count}, {28'b0, exp_cnt});
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      frame = '0;
      abort = 1'b0;
      #23;
      check("rst_ready", {31'b0, ready}, 32'd1);
      check("rst_valid", {31'b0, data_valid}, 32'd0);
      check("rst_done", {31'b0, done}, 32'd0);
      check("rst_aborted", {31'b0, aborted}, 32'd0);
      check("rst_count", {28'b0, run_count}, 32'd0);
      check("rst_dout", {31'b0, data_out}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      start_frame(8'h6E);
      check_frame("f6e", 8'h6E, 4'd2, 1'b0);
      finish_frame("f6e", 4'd2);
      start_frame(8'h55);
      check_frame("f55", 8'h55, 4'd0, 1'b0);
      finish_frame("f55", 4'd0);
      start_frame(8'hFF);
      check_frame("fff", 8'hFF, 4'd1, 1'b0);
      finish_frame("fff", 4'd1);
      start_frame(8'hDB);
      check_frame("fdb", 8'hDB, 4'd3, 1'b0);
      finish_frame("fdb", 4'd3);

      // Back-to-back with start held high
      start = 1'b1;
      frame = 8'h81;
      @(negedge clk);
      frame = 8'h03;
      check_frame_hold();
      check("b2b_idle_ready", {31'b0, ready}, 32'd1);
      check("b2b_idle_valid", {31'b0, data_valid}, 32'd0);
      @(negedge clk);
      start = 1'b0;
      check("b2b_second_accept", {31'b0, data_valid}, 32'd1);
      check_frame("f03", 8'h03, 4'd1, 1'b0);
      finish_frame("f03", 4'd1);

      // Abort in the third SHIFT cycle
      start_frame(8'hFF);
      @(negedge clk);
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_valid", {31'b0, data_valid}, 32'd0);
      check("abort_pulse", {31'b0, aborted}, 32'd1);
      check("abort_count", {28'b0, run_count}, 32'd0);
      check("abort_no_done", {31'b0, done}, 32'd0);
      start_frame(8'h06);
      check("abort_pulse_once", {31'b0, aborted}, 32'd0);
      check("abort_no_late_done", {31'b0, done}, 32'd0);
      check_frame("f06", 8'h06, 4'd1, 1'b0);
      finish_frame("f06", 4'd1);

      // start with a different frame mid-SHIFT must be ignored
      start_frame(8'h6E);
      check_frame("inj", 8'h6E, 4'd2, 1'b1);
      finish_frame("inj", 4'd2);

      // Asynchronous reset between edges mid-frame
      start_frame(8'hFF);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("arst_ready", {31'b0, ready}, 32'd1);
      check("arst_valid", {31'b0, data_valid}, 32'd0);
      check("arst_dout", {31'b0, data_out}, 32'd0);
      check("arst_done", {31'b0, done}, 32'd0);
      check("arst_count", {28'b0, run_count}, 32'd0);
      check("arst_aborted", {31'b0, aborted}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      start_frame(8'h6E);
      check_frame("post_rst", 8'h6E, 4'd2, 1'b0);
      finish_frame("post_rst", 4'd2);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // First back-to-back frame: start stays high through the frame.
   task automatic check_frame_hold();
      check_frame("f81", 8'h81, 4'd0, 1'b0);
      start = 1'b1;
      @(negedge clk);
   endtask

endmodule
